// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - access types, FSM states and lane/extension helpers for dm_access_unit
package dm_pkg;

    typedef enum logic [2:0] {
        DM_LD_NONE = 3'd0,
        DM_LB      = 3'd1,
        DM_LH      = 3'd2,
        DM_LW      = 3'd3,
        DM_LBU     = 3'd4,
        DM_LHU     = 3'd5
    } dm_read_e;

    typedef enum logic [1:0] {
        DM_ST_NONE = 2'd0,
        DM_SB      = 2'd1,
        DM_SH      = 2'd2,
        DM_SW      = 2'd3
    } dm_write_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } dm_state_e;

    // Byte enables for a store; loads (type none) never write.
    function automatic logic [3:0] dm_wstrb(input dm_write_e wt, input logic [1:0] a);
        logic [3:0] s;
        case (wt)
            DM_SB:   s = 4'b0001 << a;
            DM_SH:   s = a[1] ? 4'b1100 : 4'b0011;
            DM_SW:   s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Pick the addressed byte/half out of the bus word and extend it.
    function automatic logic [31:0] dm_load_ext(input dm_read_e rt, input logic [1:0] a,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (rt)
            DM_LB:   r = {{24{b[7]}}, b};
            DM_LH:   r = {{16{h[15]}}, h};
            DM_LW:   r = w;
            DM_LBU:  r = {24'h0, b};
            DM_LHU:  r = {16'h0, h};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Access wider than a byte whose low address bits do not match its size.
    function automatic logic dm_misaligned(input logic [2:0] rt, input logic [1:0] wt,
                                           input logic [1:0] a);
        logic m;
        if (wt != DM_ST_NONE) begin
            m = ((wt == DM_SH) && a[0]) || ((wt == DM_SW) && (a != 2'b00));
        end else begin
            m = (((rt == DM_LH) || (rt == DM_LHU)) && a[0]) ||
                ((rt == DM_LW) && (a != 2'b00));
        end
        return m;
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - store lane replication and load extract/extend
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  st_type,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    // Replicate the store operand across every lane it could land in.
    always_comb begin
        st_wdata = 32'h0;
        case (dm_write_e'(st_type))
            DM_SB:   st_wdata = {4{st_data[7:0]}};
            DM_SH:   st_wdata = {2{st_data[15:0]}};
            DM_SW:   st_wdata = st_data;
            default: st_wdata = 32'h0;
        endcase
    end

    // Extract and extend the addressed part of the returned word.
    always_comb begin
        ld_data = dm_load_ext(dm_read_e'(ld_type), ld_lane, ld_word);
    end

endmodule

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - MEM-stage load/store bus engine; optional DM_MISALIGN_TRAP_EN
module dm_access_unit
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  i_DM_read,
    input  logic [1:0]  i_DM_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    input  logic        i_wait_WFI,
    output logic        o_wait_DM1,
    output logic [31:0] o_dm_out,
    output logic        o_misaligned,
    output logic        o_dm_req,
    input  logic        i_dm_gnt,
    output logic        o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [3:0]  o_dm_wstrb,
    output logic [31:0] o_dm_wdata,
    input  logic        i_dm_rvalid,
    input  logic [31:0] i_dm_rdata
);

    dm_state_e   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  rtype_q, rtype_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] dm_out_q, dm_out_d;

    logic        is_read, is_write, access_valid, access_mis;
    logic [31:0] st_wdata, ld_data;

    assign is_read      = (i_DM_read >= 3'd1) && (i_DM_read <= 3'd5);
    assign is_write     = (i_DM_write != 2'd0);
    assign access_valid = is_read || is_write;

    dm_lane_align u_lane_align (
        .st_type  (i_DM_write),
        .st_data  (i_store_data),
        .st_wdata (st_wdata),
        .ld_type  (rtype_q),
        .ld_lane  (lane_q),
        .ld_word  (i_dm_rdata),
        .ld_data  (ld_data)
    );

`ifdef DM_MISALIGN_TRAP_EN
    logic mis_q, mis_d;

    assign access_mis   = dm_misaligned(i_DM_read, i_DM_write, i_addr[1:0]);
    assign o_misaligned = mis_q;

    // One-cycle pulse for a trapped access seen in IDLE.
    always_comb begin
        mis_d = (state_q == ST_IDLE) && access_valid && access_mis;
    end

    // Misalignment pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mis_q <= 1'b0;
        else      mis_q <= mis_d;
    end
`else
    assign access_mis   = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    // Next state, latched bus fields and the combinational stall request.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        rtype_d    = rtype_q;
        lane_d     = lane_q;
        dm_out_d   = dm_out_q;
        o_wait_DM1 = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access_valid && !access_mis) begin
                    o_wait_DM1 = 1'b1;
                    addr_d     = {i_addr[31:2], 2'b00};
                    we_d       = is_write;
                    wstrb_d    = dm_wstrb(dm_write_e'(i_DM_write), i_addr[1:0]);
                    wdata_d    = st_wdata;
                    rtype_d    = is_write ? 3'd0 : i_DM_read;
                    lane_d     = i_addr[1:0];
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                o_wait_DM1 = 1'b1;
                if (i_dm_gnt) state_d = ST_RESP;
            end
            ST_RESP: begin
                o_wait_DM1 = 1'b1;
                if (i_dm_rvalid) begin
                    if (!we_q) dm_out_d = ld_data;
                    state_d = ST_DONE;
                end
            end
            default: begin
                // The instruction is still at the inputs here, so they are ignored.
                if (!i_wait_WFI) state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'h0;
            we_q     <= 1'b0;
            wstrb_q  <= 4'h0;
            wdata_q  <= 32'h0;
            rtype_q  <= 3'd0;
            lane_q   <= 2'd0;
            dm_out_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wstrb_q  <= wstrb_d;
            wdata_q  <= wdata_d;
            rtype_q  <= rtype_d;
            lane_q   <= lane_d;
            dm_out_q <= dm_out_d;
        end
    end

    assign o_dm_req   = (state_q == ST_REQ);
    assign o_dm_we    = we_q;
    assign o_dm_addr  = addr_q;
    assign o_dm_wstrb = wstrb_q;
    assign o_dm_wdata = wdata_q;
    assign o_dm_out   = dm_out_q;

endmodule
